// File: rtl/random_pulse_gen_mc.sv
// random_pulse_gen_mc: multi-channel random pulse generator.
// One shared Fibonacci LFSR feeds every channel. Each channel takes its own
// rotated view of the LFSR, so all channels see different gap values.
// Each channel runs an IDLE/GAP/PULSE machine: a gap of G cycles, then a pulse
// pulse_width+1 cycles wide, then the next gap. mode selects random gaps or
// fixed (periodic) gaps.
module random_pulse_gen_mc #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int PW_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                mode,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  input  logic [WIDTH-1:0]    min_gap,
  input  logic [WIDTH-1:0]    gap_mask,
  input  logic [PW_BITS-1:0]  pulse_width,
  output logic [CHANNELS-1:0] pulse,
  output logic                pulse_any
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GAP   = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;

  // Tap masks for the maximal-length polynomials (tap n maps to bit n-1).
  localparam logic [31:0] TAPS32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                   (WIDTH == 16) ? 32'h0000_B400 :
                                   (WIDTH == 24) ? 32'h00E1_0000 :
                                                   32'h8020_0003;
  localparam logic [WIDTH-1:0] TAPS     = TAPS32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LFSR_ONE = WIDTH'(1);

  logic [WIDTH-1:0]    r_lfsr;
  logic [1:0]          r_state [CHANNELS];
  logic [WIDTH-1:0]    r_gcnt  [CHANNELS];
  logic [PW_BITS-1:0]  r_wcnt  [CHANNELS];
  logic [CHANNELS-1:0] r_pulse;
  logic                r_pulse_any;

  logic [WIDTH-1:0]    w_gap       [CHANNELS];
  logic [1:0]          w_state_nxt [CHANNELS];
  logic [WIDTH-1:0]    w_gcnt_nxt  [CHANNELS];
  logic [PW_BITS-1:0]  w_wcnt_nxt  [CHANNELS];
  logic [CHANNELS-1:0] w_pulse_nxt;

  // Shared LFSR: reseed on seed_load (zero seed replaced by 1), else advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_ONE;
    end else if (seed_load) begin
      r_lfsr <= (seed == '0) ? LFSR_ONE : seed;
    end else begin
      r_lfsr <= {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    end
  end

  // Per-channel gap candidate: rotated LFSR sample, masked, added to min_gap
  // with saturation; periodic mode uses min_gap alone.
  always_comb begin
    logic [2*WIDTH-1:0] w_rot_dbl;
    logic [WIDTH-1:0]   w_rnd;
    logic [WIDTH:0]     w_sum;
    w_rot_dbl = '0;
    w_rnd     = '0;
    w_sum     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      // Upper half of the doubled word shifted left is the left rotation.
      w_rot_dbl = {r_lfsr, r_lfsr} << ((3 * c) % WIDTH);
      w_rnd     = w_rot_dbl[2*WIDTH-1:WIDTH];
      w_sum     = {1'b0, min_gap} + {1'b0, w_rnd & gap_mask};
      if (mode) begin
        w_gap[c] = min_gap;
      end else if (w_sum[WIDTH]) begin
        w_gap[c] = '1;
      end else begin
        w_gap[c] = w_sum[WIDTH-1:0];
      end
    end
  end

  // Channel next-state: seed_load and a low enable both force IDLE.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_state_nxt[c] = r_state[c];
      w_gcnt_nxt[c]  = r_gcnt[c];
      w_wcnt_nxt[c]  = r_wcnt[c];
      w_pulse_nxt[c] = 1'b0;
      if (seed_load || !ch_en[c]) begin
        w_state_nxt[c] = S_IDLE;
      end else begin
        case (r_state[c])
          S_IDLE: begin
            w_state_nxt[c] = S_GAP;
            w_gcnt_nxt[c]  = w_gap[c];
          end
          S_GAP: begin
            if (r_gcnt[c] == '0) begin
              w_state_nxt[c] = S_PULSE;
              w_wcnt_nxt[c]  = pulse_width;
              w_pulse_nxt[c] = 1'b1;
            end else begin
              w_gcnt_nxt[c] = r_gcnt[c] - WIDTH'(1);
            end
          end
          S_PULSE: begin
            if (r_wcnt[c] == '0) begin
              w_state_nxt[c] = S_GAP;
              w_gcnt_nxt[c]  = w_gap[c];
            end else begin
              w_wcnt_nxt[c]  = r_wcnt[c] - PW_BITS'(1);
              w_pulse_nxt[c] = 1'b1;
            end
          end
          default: begin
            w_state_nxt[c] = S_IDLE;
          end
        endcase
      end
    end
  end

  // Channel state, counters and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_state[c] <= S_IDLE;
        r_gcnt[c]  <= '0;
        r_wcnt[c]  <= '0;
      end
      r_pulse     <= '0;
      r_pulse_any <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_gcnt[c]  <= w_gcnt_nxt[c];
        r_wcnt[c]  <= w_wcnt_nxt[c];
      end
      r_pulse     <= w_pulse_nxt;
      r_pulse_any <= |w_pulse_nxt;
    end
  end

  assign pulse     = r_pulse;
  assign pulse_any = r_pulse_any;

endmodule

// File: tb/tb_random_pulse_gen_mc.sv
// tb_random_pulse_gen_mc: directed bench for random_pulse_gen_mc.
// A 16-bit/4-channel instance covers LFSR sequence, periodic timing, width,
// abort, random gaps, reseed and async reset; an 8-bit/1-channel instance
// covers gap saturation.
module tb_random_pulse_gen_mc;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        mode;
  logic        seed_load;
  logic [15:0] seed;
  logic [15:0] min_gap;
  logic [15:0] gap_mask;
  logic [3:0]  pulse_width;
  logic [3:0]  pulse;
  logic        pulse_any;

  logic [0:0]  s8_ch_en;
  logic        s8_mode;
  logic        s8_seed_load;
  logic [7:0]  s8_seed;
  logic [7:0]  s8_min_gap;
  logic [7:0]  s8_gap_mask;
  logic [3:0]  s8_pw;
  logic [0:0]  s8_pulse;
  logic        s8_pulse_any;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] m16, m16_pre;
  logic [7:0]  m8, m8_pre;
  int          load_at [4];
  int          rise_at [4];
  int          fall_at [4];
  logic [3:0]  exp_r;

  random_pulse_gen_mc #(.WIDTH(16), .CHANNELS(4), .PW_BITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .mode(mode),
    .seed_load(seed_load), .seed(seed), .min_gap(min_gap),
    .gap_mask(gap_mask), .pulse_width(pulse_width),
    .pulse(pulse), .pulse_any(pulse_any)
  );

  random_pulse_gen_mc #(.WIDTH(8), .CHANNELS(1), .PW_BITS(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ch_en(s8_ch_en), .mode(s8_mode),
    .seed_load(s8_seed_load), .seed(s8_seed), .min_gap(s8_min_gap),
    .gap_mask(s8_gap_mask), .pulse_width(s8_pw),
    .pulse(s8_pulse), .pulse_any(s8_pulse_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] step16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [7:0] step8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [15:0] gap16(input logic [15:0] l, input int c);
    logic [15:0] r;
    logic [16:0] s;
    int          sh;
    sh = (3 * c) % 16;
    r  = (l << sh) | (l >> (16 - sh));
    s  = {1'b0, min_gap} + {1'b0, r & gap_mask};
    if (mode) return min_gap;
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; reference LFSRs follow what the DUTs see at the edge.
  task automatic tick();
    m16_pre = m16;
    m8_pre  = m8;
    if (!rst_n) begin
      m16 = 16'h0001;
      m8  = 8'h01;
    end else begin
      if (seed_load) m16 = (seed == 16'h0) ? 16'h0001 : seed;
      else           m16 = step16(m16);
      if (s8_seed_load) m8 = (s8_seed == 8'h0) ? 8'h01 : s8_seed;
      else              m8 = step8(m8);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Random-mode tick: gap loads at enable/fall edges, rise G+1 later,
  // high for pulse_width+1 cycles.
  task automatic rtick();
    logic [3:0]  e;
    logic [15:0] g;
    tick();
    e = '0;
    for (int c = 0; c < 4; c++) begin
      if (cyc == load_at[c]) begin
        g          = gap16(m16_pre, c);
        rise_at[c] = cyc + int'(g) + 1;
        fall_at[c] = rise_at[c] + int'(pulse_width) + 1;
        load_at[c] = fall_at[c];
      end
      e[c] = (cyc >= rise_at[c]) && (cyc < fall_at[c]);
    end
    exp_r = e;
    check("rnd_pulse", pulse, e);
    check("rnd_any", pulse_any, |e);
  endtask

  task automatic restart_model();
    for (int c = 0; c < 4; c++) begin
      load_at[c] = cyc + 1;
      rise_at[c] = 1 << 30;
      fall_at[c] = 1 << 30;
    end
  endtask

  initial begin
    logic [3:0] e4;
    logic       e1;
    rst_n = 1'b0; ch_en = '0; mode = 1'b0; seed_load = 1'b0; seed = '0;
    min_gap = '0; gap_mask = '0; pulse_width = '0;
    s8_ch_en = '0; s8_mode = 1'b0; s8_seed_load = 1'b0; s8_seed = '0;
    s8_min_gap = '0; s8_gap_mask = '0; s8_pw = '0;
    m16 = 16'h0001; m8 = 8'h01; m16_pre = m16; m8_pre = m8; exp_r = '0;

    // Reset held 3 cycles
    tick(); tick(); tick();
    check("rst_lfsr", u_dut.r_lfsr, 16'h0001);
    check("rst_pulse", pulse, 4'h0);
    check("rst_any", pulse_any, 1'b0);
    rst_n = 1'b1;

    // Full LFSR period from 1, then repeat
    for (int i = 1; i <= 65535; i++) begin
      tick();
      check("lfsr16_seq", u_dut.r_lfsr, m16);
      if (i <= 255) check("lfsr8_seq", u_dut8.r_lfsr, m8);
      if (i == 255) check("lfsr8_wrap", u_dut8.r_lfsr, 8'h01);
      if (i == 1) begin
        check("lfsr16_first", u_dut.r_lfsr, 16'h0002);
        check("idle_pulse", pulse, 4'h0);
        check("idle_any", pulse_any, 1'b0);
      end
    end
    check("lfsr16_wrap", u_dut.r_lfsr, 16'h0001);

    // Periodic, single channel: min_gap 3, width 1 cycle
    mode = 1'b1; min_gap = 16'd3; gap_mask = 16'h0; pulse_width = 4'd0;
    ch_en = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      e4 = (k >= 4 && (k - 4) % 5 == 0) ? 4'b0001 : 4'b0000;
      check("per_pulse", pulse, e4);
      check("per_any", pulse_any, |e4);
    end
    ch_en = 4'b0000;
    tick();
    check("per_off", pulse, 4'h0);

    // Width 6, gap 2, period 9; abort on third high cycle of third pulse
    min_gap = 16'd2; pulse_width = 4'd5; ch_en = 4'b0001;
    for (int k = 0; k < 24; k++) begin
      tick();
      e4 = ((k >= 3 && k <= 8) || (k >= 12 && k <= 17) || k >= 21) ? 4'b0001 : 4'b0000;
      check("wid_pulse", pulse, e4);
      check("wid_any", pulse_any, |e4);
    end
    ch_en = 4'b0000;
    tick();
    check("abort_pulse", pulse, 4'h0);
    check("abort_any", pulse_any, 1'b0);

    // Random mode, all channels; seed_load beats the simultaneous enable rise
    mode = 1'b0; min_gap = 16'd4; gap_mask = 16'h000F; pulse_width = 4'd1;
    ch_en = 4'b1111; seed_load = 1'b1; seed = 16'hACE1;
    tick();
    check("seed_lfsr", u_dut.r_lfsr, 16'hACE1);
    check("seed_pulse", pulse, 4'h0);
    seed_load = 1'b0;
    restart_model();
    for (int k = 0; k < 100; k++) rtick();

    // Reseed with zero mid-run
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    check("reseed_pulse", pulse, 4'h0);
    check("reseed_any", pulse_any, 1'b0);
    check("reseed_lfsr", u_dut.r_lfsr, 16'h0001);
    seed_load = 1'b0;
    restart_model();
    rtick(); rtick(); rtick();
    check("reseed_seq", u_dut.r_lfsr, 16'h0008);
    for (int k = 0; k < 60; k++) rtick();

    // Async reset while a pulse is high
    for (int i = 0; i < 40 && exp_r == 4'h0; i++) rtick();
    check("async_setup", {31'b0, |pulse}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pulse", pulse, 4'h0);
    check("async_any", pulse_any, 1'b0);
    check("async_lfsr", u_dut.r_lfsr, 16'h0001);
    tick();
    ch_en = 4'b0000;
    rst_n = 1'b1;

    // Saturation on the 8-bit instance: 0xF8 + 0xFF clamps to 255
    s8_mode = 1'b0; s8_min_gap = 8'hF8; s8_gap_mask = 8'hFF; s8_pw = 4'd0;
    s8_ch_en = 1'b1; s8_seed_load = 1'b1; s8_seed = 8'hFF;
    tick();
    check("sat_seed", u_dut8.r_lfsr, 8'hFF);
    check("sat_idle", s8_pulse, 1'b0);
    s8_seed_load = 1'b0;
    // Rise at 0+255+1; refill sample after 257 steps is 0xFC, so next rise 513.
    for (int k = 0; k <= 514; k++) begin
      tick();
      e1 = (k == 256 || k == 513);
      check("sat_pulse", s8_pulse, e1);
      check("sat_any", s8_pulse_any, e1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/random_pulse_gen_mc.md
# random_pulse_gen_mc

Multi-channel random pulse generator for the test/stimulus area. One shared maximal-length LFSR drives up to CHANNELS independent channels. Each channel emits pulses of programmable width separated by pseudo-random gaps: a minimum gap plus a masked LFSR sample. A periodic mode is provided for deterministic bring-up, along with synchronous reseeding and per-channel enables.

## Interface
- WIDTH, 16: LFSR and gap-counter width; legal values 8, 16, 24, 32.
- CHANNELS, 4: number of pulse channels, 1..8.
- PW_BITS, 4: width of the pulse-width field.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ch_en  in  CHANNELS  per-channel enable, level-sensitive.
- mode  in  1  0 = random gap, 1 = periodic (gap = min_gap).
- seed_load  in  1  synchronous reseed strobe.
- seed  in  WIDTH  seed value, used when seed_load = 1.
- min_gap  in  WIDTH  minimum gap in cycles, shared by all channels.
- gap_mask  in  WIDTH  AND-mask applied to the random term.
- pulse_width  in  PW_BITS  high time minus 1, in cycles.
- pulse  out  CHANNELS  registered pulse outputs.
- pulse_any  out  1  registered OR of all channels' next pulse values; asserts in the same cycle as pulse.

## Operation
- **LFSR**
  - Fibonacci form: shift left, feedback XOR into bit 0.
  - Taps (1-based) per WIDTH: 8 = {8,6,5,4}; 16 = {16,14,13,11}; 24 = {24,23,22,17}; 32 = {32,22,2,1}.
  - Advances every cycle except a seed_load cycle.
  - seed_load = 1 loads seed, or 1 if seed == 0, which prevents lockup.
  - Reset value is 1.
- **Channel sample**
  - rnd_c = LFSR rotated left by (3*c) mod WIDTH, where c is the channel index.
  - The sample uses the LFSR value present in the cycle the gap is loaded.
- **Gap value**
  - mode = 0: G = min_gap + (rnd_c & gap_mask), computed in WIDTH+1 bits and saturated to 2^WIDTH-1.
  - mode = 1: G = min_gap.
- **Per-channel FSM**
  - IDLE: pulse = 0. If ch_en[c] = 1, load counter with G and go to GAP.
  - GAP: if the counter is 0, go to PULSE, load the width counter with pulse_width and set pulse = 1; otherwise decrement the counter.
  - PULSE: pulse = 1. If the width counter is 0, set pulse = 0, load a new G and go to GAP; otherwise decrement.
  - ch_en[c] = 0 in any state: next state IDLE, pulse = 0 on the next edge. This aborts a pulse in progress.
  - seed_load = 1: all channels go to IDLE and all pulses drop on the next edge. Channels restart on the following cycle using the new seed.
- **Register updates**
  - mode, min_gap, gap_mask and pulse_width are sampled only at gap/width load.
  - Changes made mid-gap or mid-pulse take effect at the next load.

## Timing
- Reset: LFSR = 1, all channels IDLE, counters 0, pulse = 0, pulse_any = 0.
- Edge E0 with ch_en high in IDLE loads gap G.
- pulse rises at edge E0+G+1 and stays high for pulse_width+1 cycles.
- Steady-state period is G + pulse_width + 2 cycles, where G is the gap loaded at each cycle.
- G = 0 with pulse_width = 0 gives a 1-high/1-low alternation; pulse never stays high back-to-back across periods.
- Saturation example, WIDTH = 16: min_gap = 0xFFF0 and mask = 0xFFFF give G = 0xFFFF, with no wrap.
- Simultaneous seed_load and ch_en rise: seed_load wins and the channel stays IDLE for that cycle.
- Deasserting rst_n mid-pulse clears pulse asynchronously.

## Test plan
- **Reset:** hold rst_n low 3 cycles, then release with ch_en = 0 -> pulse = 0 and pulse_any = 0; the LFSR sequence from value 1 matches the reference model for 2^WIDTH-1 steps, then repeats.
- **Periodic, single channel:** mode = 1, min_gap = 3, pulse_width = 0, ch_en = 0001 -> first pulse 4 cycles after enable edge, then one 1-cycle pulse every 5 cycles; other channels stay 0.
- **Width and abort:** mode = 1, min_gap = 2, pulse_width = 5 -> 6-cycle pulses, period 9; drop ch_en during the 3rd high cycle -> pulse is 0 on the next edge.
- **Random mode, all channels:** seed = 0xACE1, min_gap = 4, gap_mask = 0x000F -> every gap is in 4..19, channels differ per the rotation model, and pulse_any equals the OR of pulse.
- **Reseed:** seed_load with seed = 0 mid-run -> all pulses 0 next edge, LFSR = 1, and the sequence restarts identically to post-reset.
- **Saturation:** WIDTH = 8, min_gap = 0xF8, gap_mask = 0xFF, LFSR forced high -> G clamps at 255, period = 255 + pulse_width + 2.
